dmem_access_ctrl: RTL
=====================

Name: dmem_access_ctrl

Overview:
- Sequencer and arbiter in front of the byte-addressed, word-wide data memory. Memory reads are combinational; writes are a full 32-bit word on posedge clk.
- Shares the memory between two requesters: port 0 is the core load/store unit, port 1 is the debug/loader port.
- Arbitration is round-robin.
- Provides byte, halfword and word loads with sign/zero extension, and sub-word stores via read-modify-write.
- Flags misaligned and out-of-range accesses without touching memory.

Parameters:
- MEM_BYTES, 65536: memory size in bytes; the accessed bytes must lie in [0, MEM_BYTES-1].

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-port request valid; bit i = port i
- req_ready  out  2  per-port accept; a request transfers when valid and ready are both 1
- req_we  in  2  per-port 1 = store, 0 = load
- req_size  in  4  per-port [2i+1:2i]: 00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  2  per-port zero-extend on load
- req_addr  in  64  per-port byte address [32i+31:32i]
- req_wdata  in  64  per-port store data [32i+31:32i], right-aligned
- rsp_valid  out  2  one-cycle response pulse to the owning port
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, illegal size or out-of-range; valid with rsp_valid
- mem_we  out  1  memory write enable
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  combinational memory read data at mem_addr

Behaviour:
- States: IDLE, ACCESS, MERGE_WR, RESP. Reset (async): state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
- mem_we is decoded from state, not registered, so reset deasserts it immediately. Reset mid-operation drops the transaction: no write, no response.
- IDLE: req_ready is combinational. Only the winner sees 1, and only in IDLE.
- Arbitration: if one port is valid, it wins. If both are valid, port rr_ptr wins. On grant, rr_ptr <= ~winner.
- On grant, latch id, we, size, unsigned, addr, wdata, then go to ACCESS. Requesters hold their signals stable until accepted.
- Error check at grant: error if size=11; or half with addr[0]=1; or word with addr[1:0]!=0; or last byte addr > MEM_BYTES-1. An error goes IDLE->RESP directly with rsp_err=1, rsp_rdata=0 and no memory access.
- ACCESS: mem_addr is driven.
  - Load: extract the lane at addr[1:0] (byte) or addr[1] (half), extend (sign unless unsigned), register it into rsp_rdata, go to RESP.
  - Word store: mem_we=1, mem_wdata=wdata, go to RESP.
  - Sub-word store: capture mem_rdata into the merge buffer, go to MERGE_WR.
- MERGE_WR: mem_we=1. mem_wdata = buffer with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0]. Go to RESP.
- RESP: rsp_valid[id]=1 for exactly one cycle with rsp_err; return to IDLE. Grants are not pipelined, so the next grant is at the earliest the cycle after RESP.
- Latency from the grant cycle T:
  - load or word store: rsp at T+2
  - sub-word store: rsp at T+3
  - error: rsp at T+1
- mem_addr and mem_wdata are don't-care outside ACCESS/MERGE_WR but hold their last value.
- Stores are visible to a load granted after their RESP.

Test Plan:
- Reset mid-MERGE_WR of a byte store to addr 0x20 holding 0xAABBCCDD -> mem_we drops immediately, memory stays 0xAABBCCDD, no rsp_valid. After release, port 0 load word 0x20 -> 0xAABBCCDD.
- Port 0 word store 0x12345678 @0x100, then load byte @0x103 signed -> rsp_rdata=0x00000012 at T+2, rsp_err=0. Load half @0x102 -> 0x00001234.
- Word 0x000080FF @0x40: load byte @0x40 signed -> 0xFFFFFFFF. Load half @0x40 signed -> 0xFFFF80FF. Load half unsigned -> 0x000080FF.
- Byte store 0xEE @0x101 over 0x12345678 -> MERGE_WR writes 0x1234EE78, rsp at T+3. Half store 0xBEEF @0x102 -> 0xBEEFEE78.
- Both ports valid every cycle from reset -> grants alternate 0,1,0,1. Each rsp_valid pulse goes only to the owner. No port is granted twice consecutively while the other is waiting.
- Errors, each with rsp at T+1, rsp_err=1, mem_we never 1:
  - word load @0x102
  - half store @0x0FF
  - size=11
  - word @MEM_BYTES-2

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl
//   Sequencer and round-robin arbiter that shares a byte-addressed, word-wide
//   data memory between two requesters. Port 0 is the core load/store unit
//   and port 1 is the debug/loader port. It supports byte, halfword and word
//   loads with sign or zero extension. Sub-word stores are done as a
//   read-modify-write. Misaligned, illegal-size and out-of-range accesses are
//   flagged and never reach the memory.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   req_valid[1:0]  per-port request valid
//   req_ready[1:0]  per-port accept (combinational, only in IDLE, winner only)
//   req_we[1:0]     per-port store (1) / load (0)
//   req_size[3:0]   per-port size [2i+1:2i]: 00 byte, 01 half, 10 word
//   req_unsigned    per-port zero-extend on load
//   req_addr[63:0]  per-port byte address [32i+31:32i]
//   req_wdata[63:0] per-port right-aligned store data
//   rsp_valid[1:0]  one-cycle response pulse to the owning port
//   rsp_rdata       extended load data (0 for stores and errors)
//   rsp_err         access error, valid with rsp_valid
//   mem_we          memory write enable (decoded from state)
//   mem_addr        word-aligned memory address
//   mem_wdata       memory write data
//   mem_rdata       combinational memory read data at mem_addr
module dmem_access_ctrl #(
  parameter int unsigned MEM_BYTES = 65536
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [1:0]  req_we,
  input  logic [3:0]  req_size,
  input  logic [1:0]  req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    MERGE_WR = 2'd2,
    RESP     = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_t;

  // Attributes of the accepted request that are still needed after grant.
  // The full address is not kept because mem_addr already holds the word
  // address. Only the low half of the store data is kept, because a word
  // store puts its data straight into mem_wdata at grant.
  typedef struct packed {
    logic        id;
    logic        we;
    size_t       size;
    logic        uns;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } txn_t;

  localparam logic [32:0] LAST_ADDR = 33'(MEM_BYTES - 1);

  state_t      state, state_next;
  logic        rr_ptr;
  txn_t        txn;

  logic        winner;
  logic        grant;
  logic        sel_we;
  size_t       sel_size;
  logic        sel_uns;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;
  logic [32:0] last_byte;

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;
  logic [31:0] merged;
  logic        word_store;
  logic [1:0]  owner_onehot;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester wins. When both are valid, rr_ptr picks.
  // ---------------------------------------------------------------------------
  assign winner = (req_valid == 2'b10) ? 1'b1 :
                  (req_valid == 2'b01) ? 1'b0 : rr_ptr;
  assign grant  = (state == IDLE) && (|req_valid);

  // Gated by reset so that an asserted reset shows no accept, even though
  // the state register already sits in IDLE.
  assign req_ready = (grant && !reset) ? (winner ? 2'b10 : 2'b01) : 2'b00;

  assign sel_we    = winner ? req_we[1]       : req_we[0];
  assign sel_size  = size_t'(winner ? req_size[3:2] : req_size[1:0]);
  assign sel_uns   = winner ? req_unsigned[1] : req_unsigned[0];
  assign sel_addr  = winner ? req_addr[63:32]  : req_addr[31:0];
  assign sel_wdata = winner ? req_wdata[63:32] : req_wdata[31:0];

  // Error check on the request being granted. The last byte address is
  // computed one bit wider so an access near 2^32 cannot wrap past the
  // range check.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    sel_err   = 1'b0;
    last_byte = {1'b0, sel_addr};
    unique case (sel_size)
      SZ_BYTE: last_byte = {1'b0, sel_addr};
      SZ_HALF: begin
        sel_err   = sel_addr[0];
        last_byte = {1'b0, sel_addr} + 33'd1;
      end
      SZ_WORD: begin
        sel_err   = |sel_addr[1:0];
        last_byte = {1'b0, sel_addr} + 33'd3;
      end
      default: sel_err = 1'b1;
    endcase
    if (last_byte > LAST_ADDR) sel_err = 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Load lane extraction and sub-word store merge, both from mem_rdata.
  // ---------------------------------------------------------------------------
  always_comb begin
    byte_lane = mem_rdata[7:0];
    unique case (txn.lane)
      2'd0: byte_lane = mem_rdata[7:0];
      2'd1: byte_lane = mem_rdata[15:8];
      2'd2: byte_lane = mem_rdata[23:16];
      2'd3: byte_lane = mem_rdata[31:24];
    endcase
    half_lane = txn.lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    load_data = mem_rdata;
    unique case (txn.size)
      SZ_BYTE: load_data = txn.uns ? {24'd0, byte_lane}
                                   : {{24{byte_lane[7]}}, byte_lane};
      SZ_HALF: load_data = txn.uns ? {16'd0, half_lane}
                                   : {{16{half_lane[15]}}, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (txn.size == SZ_BYTE) begin
      unique case (txn.lane)
        2'd0: merged[7:0]   = txn.wdata[7:0];
        2'd1: merged[15:8]  = txn.wdata[7:0];
        2'd2: merged[23:16] = txn.wdata[7:0];
        2'd3: merged[31:24] = txn.wdata[7:0];
      endcase
    end else if (txn.lane[1]) begin
      merged[31:16] = txn.wdata;
    end else begin
      merged[15:0] = txn.wdata;
    end
  end

  assign word_store   = txn.we && (txn.size == SZ_WORD);
  assign owner_onehot = txn.id ? 2'b10 : 2'b01;

  // Decoded from state so that an asynchronous reset removes the write
  // enable at once. A transaction in progress is then dropped.
  assign mem_we = ((state == ACCESS) && word_store) || (state == MERGE_WR);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (grant) state_next = sel_err ? RESP : ACCESS;
      ACCESS:   state_next = (txn.we && !word_store) ? MERGE_WR : RESP;
      MERGE_WR: state_next = RESP;
      RESP:     state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments, so every
    // register samples pre-edge values and process order cannot matter.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr    <= 1'b0;
      txn       <= '0;
      rsp_valid <= 2'b00;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      // The response pulse is set only on the edge that enters RESP.
      rsp_valid <= 2'b00;
      unique case (state)
        IDLE: begin
          if (grant) begin
            rr_ptr    <= ~winner;
            txn.id    <= winner;
            txn.we    <= sel_we;
            txn.size  <= sel_size;
            txn.uns   <= sel_uns;
            txn.lane  <= sel_addr[1:0];
            txn.wdata <= sel_wdata[15:0];
            rsp_rdata <= 32'd0;
            rsp_err   <= sel_err;
            if (sel_err) begin
              // Errors skip the memory entirely and answer next cycle.
              rsp_valid <= winner ? 2'b10 : 2'b01;
            end else begin
              mem_addr <= {sel_addr[31:2], 2'b00};
              if (sel_we) mem_wdata <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          if (!txn.we) begin
            rsp_rdata <= load_data;
            rsp_valid <= owner_onehot;
          end else if (word_store) begin
            rsp_valid <= owner_onehot;
          end else begin
            // mem_wdata acts as the merge buffer. It captures the current
            // word with the addressed lane(s) already replaced, and is
            // written back during MERGE_WR.
            mem_wdata <= merged;
          end
        end
        MERGE_WR: rsp_valid <= owner_onehot;
        RESP:     ;
      endcase
    end
  end

endmodule
